// File: rtl/butterfly2_pipe_if.sv
// Handshake and data bundle for the streaming radix-2 butterfly.
// Ports: i_valid/o_ready operand handshake; A, B, twiddle and mode bits in;
//        o_valid/i_ready result handshake; out0/out1, sticky o_ovf and its clear.
interface butterfly2_pipe_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_valid;
  logic                 o_ready;
  logic [WORD_SIZE-1:0] i_in0_re;
  logic [WORD_SIZE-1:0] i_in0_im;
  logic [WORD_SIZE-1:0] i_in1_re;
  logic [WORD_SIZE-1:0] i_in1_im;
  logic [WORD_SIZE-1:0] i_twiddle_re;
  logic [WORD_SIZE-1:0] i_twiddle_im;
  logic                 i_inverse;
  logic                 i_scale;
  logic                 o_valid;
  logic                 i_ready;
  logic [WORD_SIZE-1:0] o_out0_re;
  logic [WORD_SIZE-1:0] o_out0_im;
  logic [WORD_SIZE-1:0] o_out1_re;
  logic [WORD_SIZE-1:0] o_out1_im;
  logic                 o_ovf;
  logic                 i_clr_ovf;

  // Producer/consumer side (drives operands, receives results).
  modport master (
    output i_valid, i_in0_re, i_in0_im, i_in1_re, i_in1_im,
           i_twiddle_re, i_twiddle_im, i_inverse, i_scale, i_ready, i_clr_ovf,
    input  o_ready, o_valid, o_out0_re, o_out0_im, o_out1_re, o_out1_im, o_ovf
  );

  // Butterfly side.
  modport slave (
    input  i_valid, i_in0_re, i_in0_im, i_in1_re, i_in1_im,
           i_twiddle_re, i_twiddle_im, i_inverse, i_scale, i_ready, i_clr_ovf,
    output o_ready, o_valid, o_out0_re, o_out0_im, o_out1_re, o_out1_im, o_ovf
  );
endinterface

// File: rtl/butterfly2_pipe.sv
// Purpose: pipelined radix-2 DIT complex butterfly, out0 = A + W'B, out1 = A - W'B.
// Latency: 3 enabled clock edges from input transfer to o_valid; one set per cycle.
// Backpressure: a single enable (!o_valid | i_ready) stalls every stage; o_ready = enable.
// Ports: i_clk, i_rst_n (async active-low); bus carries the operand/result handshakes,
//        operands, twiddle, inverse/scale mode bits, results and the sticky overflow flag.
module butterfly2_pipe #(
  parameter int WORD_SIZE = 16,
  parameter int FRACTION  = 8,
  parameter int ROUND     = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  butterfly2_pipe_if.slave bus
);

  localparam int W  = WORD_SIZE;
  localparam int PW = 2 * W;      // product width
  localparam int SW = 2 * W + 1;  // stage-2 sum width, also reused for stage-3 math

  localparam logic signed [SW-1:0] RND2 = (ROUND != 0) ? (SW'(1) << (FRACTION - 1)) : '0;
  localparam logic signed [SW-1:0] RND3 = (ROUND != 0) ? SW'(1) : '0;
  localparam logic signed [SW-1:0] MAXV = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};

  // Returns {saturated, value} for a W-bit signed result.
  function automatic logic [W:0] sat_w(input logic signed [SW-1:0] v);
    logic [W:0] r;
    if (v > MAXV)      r = {1'b1, 1'b0, {(W - 1){1'b1}}};
    else if (v < MINV) r = {1'b1, 1'b1, {(W - 1){1'b0}}};
    else               r = {1'b0, v[W-1:0]};
    return r;
  endfunction

  // A +/- P; the halved path cannot exceed W bits so its flag is always clear.
  function automatic logic [W:0] stage3(input logic signed [W-1:0] a,
                                        input logic signed [W-1:0] p,
                                        input logic sub, input logic scale);
    logic signed [SW-1:0] a_x;
    logic signed [SW-1:0] p_x;
    logic signed [SW-1:0] s;
    a_x = {{(W + 1){a[W-1]}}, a};
    p_x = {{(W + 1){p[W-1]}}, p};
    s   = sub ? (a_x - p_x) : (a_x + p_x);
    if (scale) s = (s + RND3) >>> 1;
    return sat_w(s);
  endfunction

  logic en;

  // stage 1: A, scale bit, four partial products
  logic                 s1_vld_q, s1_vld_d;
  logic signed [W-1:0]  s1_a_re_q, s1_a_re_d, s1_a_im_q, s1_a_im_d;
  logic                 s1_scale_q, s1_scale_d;
  logic signed [PW-1:0] s1_rr_q, s1_rr_d, s1_ii_q, s1_ii_d;
  logic signed [PW-1:0] s1_ri_q, s1_ri_d, s1_ir_q, s1_ir_d;
  // stage 2: A, scale bit, rounded/saturated W'B
  logic                 s2_vld_q, s2_vld_d;
  logic signed [W-1:0]  s2_a_re_q, s2_a_re_d, s2_a_im_q, s2_a_im_d;
  logic                 s2_scale_q, s2_scale_d;
  logic signed [W-1:0]  s2_p_re_q, s2_p_re_d, s2_p_im_q, s2_p_im_d;
  // stage 3: results
  logic                 out_vld_q, out_vld_d;
  logic [W-1:0]         out0_re_q, out0_re_d, out0_im_q, out0_im_d;
  logic [W-1:0]         out1_re_q, out1_re_d, out1_im_q, out1_im_d;
  logic                 ovf_q, ovf_d;

  // combinational intermediates
  logic signed [PW-1:0] b_re_x, b_im_x, w_re_x, w_im_x;
  logic signed [SW-1:0] sum_re, sum_im;
  logic [W:0]           p_re_sat, p_im_sat;
  logic [W:0]           r0_re, r0_im, r1_re, r1_im;
  logic                 sat2, sat3;

  always_comb begin
    en = !out_vld_q | bus.i_ready;

    // Stage 1 math. Widening the twiddle before negation lets the most
    // negative value conjugate to its exact positive counterpart.
    b_re_x = {{W{bus.i_in1_re[W-1]}}, bus.i_in1_re};
    b_im_x = {{W{bus.i_in1_im[W-1]}}, bus.i_in1_im};
    w_re_x = {{W{bus.i_twiddle_re[W-1]}}, bus.i_twiddle_re};
    w_im_x = {{W{bus.i_twiddle_im[W-1]}}, bus.i_twiddle_im};
    if (bus.i_inverse) w_im_x = -w_im_x;

    // Stage 2 math: differences of two PW-bit products need one extra bit.
    sum_re   = {s1_rr_q[PW-1], s1_rr_q} - {s1_ii_q[PW-1], s1_ii_q} + RND2;
    sum_im   = {s1_ri_q[PW-1], s1_ri_q} + {s1_ir_q[PW-1], s1_ir_q} + RND2;
    p_re_sat = sat_w(sum_re >>> FRACTION);
    p_im_sat = sat_w(sum_im >>> FRACTION);
    sat2     = s1_vld_q & (p_re_sat[W] | p_im_sat[W]);

    // Stage 3 math
    r0_re = stage3(s2_a_re_q, s2_p_re_q, 1'b0, s2_scale_q);
    r0_im = stage3(s2_a_im_q, s2_p_im_q, 1'b0, s2_scale_q);
    r1_re = stage3(s2_a_re_q, s2_p_re_q, 1'b1, s2_scale_q);
    r1_im = stage3(s2_a_im_q, s2_p_im_q, 1'b1, s2_scale_q);
    sat3  = s2_vld_q & (r0_re[W] | r0_im[W] | r1_re[W] | r1_im[W]);

    // hold by default
    s1_vld_d   = s1_vld_q;   s1_a_re_d  = s1_a_re_q;  s1_a_im_d = s1_a_im_q;
    s1_scale_d = s1_scale_q;
    s1_rr_d    = s1_rr_q;    s1_ii_d    = s1_ii_q;
    s1_ri_d    = s1_ri_q;    s1_ir_d    = s1_ir_q;
    s2_vld_d   = s2_vld_q;   s2_a_re_d  = s2_a_re_q;  s2_a_im_d = s2_a_im_q;
    s2_scale_d = s2_scale_q; s2_p_re_d  = s2_p_re_q;  s2_p_im_d = s2_p_im_q;
    out_vld_d  = out_vld_q;
    out0_re_d  = out0_re_q;  out0_im_d  = out0_im_q;
    out1_re_d  = out1_re_q;  out1_im_d  = out1_im_q;
    ovf_d      = ovf_q;

    if (en) begin
      s1_vld_d   = bus.i_valid;
      s1_a_re_d  = bus.i_in0_re;
      s1_a_im_d  = bus.i_in0_im;
      s1_scale_d = bus.i_scale;
      // Both operands fit in W+1 significant bits, so PW-bit products are exact.
      s1_rr_d    = b_re_x * w_re_x;
      s1_ii_d    = b_im_x * w_im_x;
      s1_ri_d    = b_re_x * w_im_x;
      s1_ir_d    = b_im_x * w_re_x;

      s2_vld_d   = s1_vld_q;
      s2_a_re_d  = s1_a_re_q;
      s2_a_im_d  = s1_a_im_q;
      s2_scale_d = s1_scale_q;
      s2_p_re_d  = p_re_sat[W-1:0];
      s2_p_im_d  = p_im_sat[W-1:0];

      out_vld_d  = s2_vld_q;
      out0_re_d  = r0_re[W-1:0];
      out0_im_d  = r0_im[W-1:0];
      out1_re_d  = r1_re[W-1:0];
      out1_im_d  = r1_im[W-1:0];
    end

    // set wins over clear
    if (bus.i_clr_ovf) ovf_d = 1'b0;
    if (en && (sat2 || sat3)) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld_q   <= 1'b0; s1_a_re_q <= '0; s1_a_im_q <= '0; s1_scale_q <= 1'b0;
      s1_rr_q    <= '0;   s1_ii_q   <= '0; s1_ri_q   <= '0; s1_ir_q    <= '0;
      s2_vld_q   <= 1'b0; s2_a_re_q <= '0; s2_a_im_q <= '0; s2_scale_q <= 1'b0;
      s2_p_re_q  <= '0;   s2_p_im_q <= '0;
      out_vld_q  <= 1'b0;
      out0_re_q  <= '0;   out0_im_q <= '0; out1_re_q <= '0; out1_im_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;   s1_a_re_q <= s1_a_re_d; s1_a_im_q <= s1_a_im_d;
      s1_scale_q <= s1_scale_d;
      s1_rr_q    <= s1_rr_d;    s1_ii_q   <= s1_ii_d;
      s1_ri_q    <= s1_ri_d;    s1_ir_q   <= s1_ir_d;
      s2_vld_q   <= s2_vld_d;   s2_a_re_q <= s2_a_re_d; s2_a_im_q <= s2_a_im_d;
      s2_scale_q <= s2_scale_d; s2_p_re_q <= s2_p_re_d; s2_p_im_q <= s2_p_im_d;
      out_vld_q  <= out_vld_d;
      out0_re_q  <= out0_re_d;  out0_im_q <= out0_im_d;
      out1_re_q  <= out1_re_d;  out1_im_q <= out1_im_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.o_ready   = en;
  assign bus.o_valid   = out_vld_q;
  assign bus.o_out0_re = out0_re_q;
  assign bus.o_out0_im = out0_im_q;
  assign bus.o_out1_re = out1_re_q;
  assign bus.o_out1_im = out1_im_q;
  assign bus.o_ovf     = ovf_q;

endmodule

// File: tb/tb_butterfly2_pipe.sv
// Bench for butterfly2_pipe: a rounding instance under random backpressure and a
// truncating instance fed the same operands with a always-ready sink.
// Arithmetic reference model plus literal expectations from hand calculation.
module tb_butterfly2_pipe;
  localparam int W    = 16;
  localparam int FRAC = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  butterfly2_pipe_if #(.WORD_SIZE(W)) bf ();
  butterfly2_pipe_if #(.WORD_SIZE(W)) bz ();

  butterfly2_pipe #(.WORD_SIZE(W), .FRACTION(FRAC), .ROUND(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bf.slave));
  butterfly2_pipe #(.WORD_SIZE(W), .FRACTION(FRAC), .ROUND(0)) dut_trunc (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bz.slave));

  // truncating instance mirrors the operand stream, never stalls
  assign bz.i_valid      = bf.i_valid;
  assign bz.i_in0_re     = bf.i_in0_re;
  assign bz.i_in0_im     = bf.i_in0_im;
  assign bz.i_in1_re     = bf.i_in1_re;
  assign bz.i_in1_im     = bf.i_in1_im;
  assign bz.i_twiddle_re = bf.i_twiddle_re;
  assign bz.i_twiddle_im = bf.i_twiddle_im;
  assign bz.i_inverse    = bf.i_inverse;
  assign bz.i_scale      = bf.i_scale;
  assign bz.i_ready      = 1'b1;
  assign bz.i_clr_ovf    = bf.i_clr_ovf;

  logic bp_en = 1'b0, rnd_rdy = 1'b1, rdy_set = 1'b1;
  assign bf.i_ready = bp_en ? rnd_rdy : rdy_set;
  always @(posedge clk) begin
    #2;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  logic [63:0] bf_outs, bz_outs;
  assign bf_outs = {bf.o_out0_re, bf.o_out0_im, bf.o_out1_re, bf.o_out1_im};
  assign bz_outs = {bz.o_out0_re, bz.o_out0_im, bz.o_out1_re, bz.o_out1_im};

  typedef struct {
    logic [63:0] val;
    int          acc;
    int          stl;
  } exp_t;

  exp_t        q_bf[$];
  exp_t        q_bz[$];
  logic [63:0] bf_log[$];
  logic [63:0] bz_log[$];
  int          total = 0, bad = 0, cyc = 0, stall = 0;
  logic        hold_prev = 1'b0;
  logic [63:0] prev_out = '0;
  exp_t        e;

  // ---------------- reference model ----------------
  function automatic longint sx(input logic [15:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint clamp(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [15:0] fin(input longint s, input int rnd, input logic sc);
    longint v;
    v = sc ? ((s + longint'(rnd)) >>> 1) : clamp(s);
    return v[15:0];
  endfunction

  function automatic logic [63:0] model(input logic [15:0] ar, ai, br, bi, wr, wi,
                                        input logic inv, sc, input int rnd);
    longint wim, pr, pi;
    wim = sx(wi);
    if (inv) wim = -wim;
    pr = sx(br) * sx(wr) - sx(bi) * wim;
    pi = sx(br) * wim + sx(bi) * sx(wr);
    if (rnd != 0) begin
      pr = pr + (longint'(1) << (FRAC - 1));
      pi = pi + (longint'(1) << (FRAC - 1));
    end
    pr = clamp(pr >>> FRAC);
    pi = clamp(pi >>> FRAC);
    return {fin(sx(ar) + pr, rnd, sc), fin(sx(ai) + pi, rnd, sc),
            fin(sx(ar) - pr, rnd, sc), fin(sx(ai) - pi, rnd, sc)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      q_bf.delete();
      q_bz.delete();
      hold_prev = 1'b0;
    end else begin
      cyc++;
      chk("o_ready_rule", 64'(bf.o_ready), 64'(!bf.o_valid | bf.i_ready));
      if (hold_prev) chk("hold_stable", {bf_outs[62:0], bf.o_valid}, {prev_out[62:0], 1'b1});
      if (bf.o_valid && bf.i_ready) begin
        if (q_bf.size() == 0) chk("bf_unexpected_output", 64'd1, 64'd0);
        else begin
          e = q_bf.pop_front();
          chk("bf_out", bf_outs, e.val);
          chk("bf_latency", 64'(cyc), 64'(e.acc + 3 + stall - e.stl));
          bf_log.push_back(bf_outs);
        end
      end
      if (bz.o_valid && bz.i_ready) begin
        if (q_bz.size() == 0) chk("bz_unexpected_output", 64'd1, 64'd0);
        else begin
          e = q_bz.pop_front();
          chk("bz_out", bz_outs, e.val);
          chk("bz_latency", 64'(cyc), 64'(e.acc + 3));
          bz_log.push_back(bz_outs);
        end
      end
      if (bf.i_valid && bf.o_ready) begin
        e.val = model(bf.i_in0_re, bf.i_in0_im, bf.i_in1_re, bf.i_in1_im,
                      bf.i_twiddle_re, bf.i_twiddle_im, bf.i_inverse, bf.i_scale, 1);
        e.acc = cyc;
        e.stl = stall;
        q_bf.push_back(e);
      end
      if (bz.i_valid && bz.o_ready) begin
        e.val = model(bz.i_in0_re, bz.i_in0_im, bz.i_in1_re, bz.i_in1_im,
                      bz.i_twiddle_re, bz.i_twiddle_im, bz.i_inverse, bz.i_scale, 0);
        e.acc = cyc;
        e.stl = 0;
        q_bz.push_back(e);
      end
      hold_prev = bf.o_valid && !bf.i_ready;
      prev_out  = bf_outs;
      if (hold_prev) stall++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [15:0] ar, ai, br, bi, wr, wi, input logic inv, sc);
    int n = 0;
    bf.i_valid = 1'b1;
    bf.i_in0_re = ar; bf.i_in0_im = ai; bf.i_in1_re = br; bf.i_in1_im = bi;
    bf.i_twiddle_re = wr; bf.i_twiddle_im = wi;
    bf.i_inverse = inv; bf.i_scale = sc;
    @(negedge clk);
    while (!bf.o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_accepted", 64'(n >= 200), 64'd0);
    @(posedge clk);
    #1;
    bf.i_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q_bf.size() != 0 || q_bz.size() != 0 || bf.o_valid || bz.o_valid) && n < 100) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk(name, 64'(n >= 100), 64'd0);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 bf.i_clr_ovf = 1'b1;
    @(posedge clk);
    #1 bf.i_clr_ovf = 1'b0;
  endtask

  function automatic logic [63:0] last_bf(input int back);
    return bf_log[bf_log.size() - 1 - back];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n = 1'b1;
    bf.i_valid = 1'b0;
    bf.i_in0_re = '0; bf.i_in0_im = '0; bf.i_in1_re = '0; bf.i_in1_im = '0;
    bf.i_twiddle_re = '0; bf.i_twiddle_im = '0;
    bf.i_inverse = 1'b0; bf.i_scale = 1'b0; bf.i_clr_ovf = 1'b0;
    rdy_set = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", 64'(bf.o_valid), 64'd0);
    chk("rst_outs", bf_outs, 64'd0);
    chk("rst_ovf", 64'(bf.o_ovf), 64'd0);
    chk("rst_o_ready", 64'(bf.o_ready), 64'd1);
    rdy_set = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // model pinned to hand-computed values
    chk("model_basic", model(16'h0100, 0, 16'h0100, 0, 16'h0100, 0, 0, 0, 1),
        {16'h0200, 16'h0000, 16'h0000, 16'h0000});
    chk("model_round0", model(0, 0, 16'h0101, 0, 16'h00B5, 16'h00B5, 0, 0, 0),
        {16'h00B5, 16'h00B5, 16'hFF4B, 16'hFF4B});

    // basic
    send(16'h0100, 0, 16'h0100, 0, 16'h0100, 0, 0, 0);
    drain("drain_basic");
    chk("basic_out", last_bf(0), {16'h0200, 16'h0000, 16'h0000, 16'h0000});
    chk("basic_ovf", 64'(bf.o_ovf), 64'd0);

    // forward then inverse, back to back
    send(16'h0100, 0, 16'h0100, 0, 16'h0000, 16'hFF00, 0, 0);
    send(16'h0100, 0, 16'h0100, 0, 16'h0000, 16'hFF00, 1, 0);
    drain("drain_inv");
    chk("fwd_out", last_bf(1), {16'h0100, 16'hFF00, 16'h0100, 16'h0100});
    chk("inv_out", last_bf(0), {16'h0100, 16'h0100, 16'h0100, 16'hFF00});

    // saturation, sticky flag, scaling
    send(16'h7F00, 0, 16'h7F00, 0, 16'h0100, 0, 0, 0);
    drain("drain_sat");
    chk("sat_out0_re", 64'(last_bf(0)[63:48]), 64'h7FFF);
    chk("sat_out1_re", 64'(last_bf(0)[31:16]), 64'h0000);
    chk("sat_ovf", 64'(bf.o_ovf), 64'd1);
    repeat (3) @(posedge clk);
    #1 chk("ovf_sticky", 64'(bf.o_ovf), 64'd1);
    send(16'h7F00, 0, 16'h7F00, 0, 16'h0100, 0, 0, 1);
    drain("drain_scale");
    chk("scale_out0_re", 64'(last_bf(0)[63:48]), 64'h7F00);
    chk("scale_ovf_kept", 64'(bf.o_ovf), 64'd1);
    pulse_clr();
    chk("ovf_cleared", 64'(bf.o_ovf), 64'd0);

    // rounding vs truncation
    send(0, 0, 16'h0101, 0, 16'h00B5, 16'h00B5, 0, 0);
    drain("drain_round");
    chk("round1_out", last_bf(0), {16'h00B6, 16'h00B6, 16'hFF4A, 16'hFF4A});
    chk("round0_out0", 64'(bz_log[bz_log.size() - 1][63:32]), 64'h00B500B5);

    // most-negative twiddle imaginary under conjugation
    send(0, 0, 16'h0080, 0, 16'h0000, 16'h8000, 1, 0);
    send(0, 0, 16'h0080, 0, 16'h0000, 16'h8000, 0, 0);
    drain("drain_conj");
    chk("conj_min_inv", last_bf(1), {16'h0000, 16'h4000, 16'h0000, 16'hC000});
    chk("conj_min_fwd", last_bf(0), {16'h0000, 16'hC000, 16'h0000, 16'h4000});
    chk("conj_min_ovf", 64'(bf.o_ovf), 64'd0);

    // random backpressure and gaps
    n0 = bf_log.size();
    bp_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(16'(i), 16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    bp_en = 1'b0;
    drain("drain_bp");
    chk("bp_count", 64'(bf_log.size() - n0), 64'd8);
    pulse_clr();

    // asynchronous reset with three sets in flight
    rdy_set = 1'b0;
    send(16'h7F00, 0, 16'h7F00, 0, 16'h0100, 0, 0, 0);
    send(16'h0001, 0, 16'h0100, 0, 16'h0100, 0, 0, 0);
    send(16'h0002, 0, 16'h0100, 0, 16'h0100, 0, 0, 0);
    #1;
    chk("pre_rst_o_valid", 64'(bf.o_valid), 64'd1);
    chk("pre_rst_ovf", 64'(bf.o_ovf), 64'd1);
    chk("pre_rst_o_ready", 64'(bf.o_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o_valid", 64'(bf.o_valid), 64'd0);
    chk("mid_rst_outs", bf_outs, 64'd0);
    chk("mid_rst_ovf", 64'(bf.o_ovf), 64'd0);
    chk("mid_rst_o_ready", 64'(bf.o_ready), 64'd1);
    @(posedge clk);
    #1 rdy_set = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    n0 = bf_log.size();
    send(16'h0100, 0, 16'h0100, 0, 16'h0100, 0, 0, 0);
    drain("drain_post_rst");
    chk("post_rst_count", 64'(bf_log.size() - n0), 64'd1);
    chk("post_rst_out", last_bf(0), {16'h0200, 16'h0000, 16'h0000, 16'h0000});

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/butterfly2_pipe.md
# butterfly2_pipe

Parametrised, fully pipelined radix-2 decimation-in-time complex butterfly in signed fixed point. It is the streaming successor of the single-shot butterfly2 stage for the 16-point FFT datapath. It accepts one operand pair plus twiddle per cycle under a valid/ready handshake and supports inverse-transform, per-stage scaling, rounding and saturation. Results appear three accepted cycles later, in order, with backpressure propagating through the whole pipe.

## Interface
Parameters:
- WORD_SIZE, 16, width of every real/imag sample and twiddle component (signed two's complement)
- FRACTION, 8, fractional bits of samples and twiddles (Q(WORD_SIZE-FRACTION).FRACTION); 1 <= FRACTION < WORD_SIZE
- ROUND, 1, 1 = round-half-up at every right shift, 0 = truncate

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input operand set valid
- o_ready  out  1  block can accept input this cycle
- i_in0_re, i_in0_im, i_in1_re, i_in1_im  in  WORD_SIZE each  operands A and B
- i_twiddle_re, i_twiddle_im  in  WORD_SIZE each  twiddle W
- i_inverse  in  1  use conj(W); sampled with the operands
- i_scale  in  1  divide both outputs by 2; sampled with the operands
- o_valid  out  1  output set valid
- i_ready  in  1  downstream accepts output
- o_out0_re, o_out0_im, o_out1_re, o_out1_im  out  WORD_SIZE each  results
- o_ovf  out  1  sticky saturation flag
- i_clr_ovf  in  1  synchronous clear of o_ovf

## Operation
- Outputs: out0 = A + W'*B and out1 = A - W'*B, where W' = W, or conj(W) when i_inverse=1.
- Conjugation: W'_im = -W_im. The most negative value negates to the most positive value and does not set o_ovf.
- Stage 1: register A, the mode bits, and the four 2*WORD_SIZE products B_re*W'_re, B_im*W'_im, B_re*W'_im, B_im*W'_re.
- Stage 2: compute P_re = rr - ii and P_im = ri + ir at 2*WORD_SIZE+1 bits.
  - If ROUND=1, add 2^(FRACTION-1).
  - Arithmetic shift right by FRACTION.
  - Saturate to WORD_SIZE bits.
- Stage 3: compute A±P at WORD_SIZE+1 bits.
  - If scale=1, add ROUND, then arithmetic shift right by 1. This always fits and never saturates.
  - Otherwise saturate to WORD_SIZE bits.
- o_ovf: set by any saturation event in stage 2 or stage 3 on a transfer that advances. Cleared by i_clr_ovf. Set has priority over clear in the same cycle.
- Flow control: pipe enable en = !o_valid | i_ready.
  - o_ready = en, combinational.
  - All three stages and their valid bits advance only when en=1.
  - Bubbles (valid=0) occupy stages and are not compressed.
- Input transfer happens when i_valid & o_ready. Output transfer happens when o_valid & i_ready.
- While o_valid=1 and i_ready=0, o_out* hold stable and nothing advances.
- Reset (asynchronous, mid-operation allowed) discards all in-flight data.
  - o_valid=0, o_out*=0, o_ovf=0, all internal valid bits 0.
  - o_ready=1 during and after reset.

## Timing
- Latency: 3 clock edges from input transfer to o_valid=1, with no stalls.
- Throughput: one set per cycle while i_ready=1.
- Stall: each cycle with en=0 adds exactly one cycle to the latency of every in-flight set.
- Ordering: strictly in order; no loss or duplication under any i_valid/i_ready pattern.
- Mode bits travel with their own data. Changing i_inverse/i_scale every cycle is legal.
- After i_rst_n deasserts, the first input transfer is allowed on the first rising edge.

## Test plan
(WORD_SIZE=16, FRACTION=8, ROUND=1 unless stated.)
- Basic: A=(0x0100,0), B=(0x0100,0), W=(0x0100,0) -> 3 cycles later out0=(0x0200,0x0000), out1=(0x0000,0x0000), o_ovf=0.
- Forward vs. inverse: A=(0x0100,0), B=(0x0100,0), W=(0x0000,0xFF00).
  - i_inverse=0 -> out0=(0x0100,0xFF00), out1=(0x0100,0x0100).
  - Next cycle, i_inverse=1 -> out0=(0x0100,0x0100), out1=(0x0100,0xFF00).
  - Both results appear on consecutive cycles.
- Saturation and scaling: A=(0x7F00,0), B=(0x7F00,0), W=(0x0100,0).
  - i_scale=0 -> out0_re=0x7FFF, out1_re=0x0000, o_ovf=1, remaining sticky until a cycle with i_clr_ovf=1.
  - i_scale=1 -> out0_re=0x7F00, o_ovf unchanged.
- Rounding: A=0, B=(0x0101,0), W=(0x00B5,0x00B5).
  - ROUND=1 -> out0=(0x00B6,0x00B6), out1=(0xFF4A,0xFF4A).
  - ROUND=0 -> out0=(0x00B5,0x00B5).
- Backpressure: stream 8 sets with distinct A_re=1..8, with random i_valid and i_ready low 50% of cycles.
  - All 8 sets emerge in order with correct values.
  - Outputs are stable whenever o_valid & !i_ready.
  - o_ready equals !o_valid | i_ready every cycle.
- Reset mid-stream: assert i_rst_n=0 asynchronously with 3 sets in flight.
  - o_valid, o_out*, and o_ovf go to 0 immediately.
  - No stale set appears after release.
  - The first new set emerges 3 cycles after acceptance.
